// File: rtl/fcvt_int64.sv
// Binary64 to signed int64 conversion with round-toward-zero (FCVT.L.D, RTZ).
// Combinational decode and shift, one registered output stage with a valid strobe.
module fcvt_int64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [63:0] fp,
    output logic        out_valid,
    output logic [63:0] in,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] NEG_2P63 = 64'hC3E0_0000_0000_0000;

    logic        sign;
    logic [10:0] exp_f;
    logic [51:0] frac;

    logic        exp_zero;
    logic        is_nan;
    logic        below_one;
    logic        too_big;
    logic        right_path;
    logic        is_min;

    logic [63:0] mant;
    logic [5:0]  rsh;
    logic [5:0]  lsh;
    logic [63:0] shr;
    logic [63:0] shl;
    logic [63:0] lost;
    logic [63:0] mag;

    logic [63:0] result;
    logic        nv;
    logic        nx;

    assign sign  = fp[63];
    assign exp_f = fp[62:52];
    assign frac  = fp[51:0];

    assign exp_zero   = (exp_f == 11'd0);
    assign is_nan     = (&exp_f) && (|frac);
    assign below_one  = (exp_f < 11'd1023);
    assign too_big    = (exp_f >= 11'd1086);
    assign right_path = (exp_f <= 11'd1075);
    assign is_min     = (fp == NEG_2P63);

    // Shift amounts are 52-E and E-52 taken modulo 64; the bias 1075 is 51 mod 64,
    // so only the low six exponent bits matter inside the in-range window.
    assign mant = {11'd0, 1'b1, frac};
    assign rsh  = 6'd51 - exp_f[5:0];
    assign lsh  = exp_f[5:0] - 6'd51;
    assign shr  = mant >> rsh;
    assign shl  = mant << lsh;
    assign lost = mant & ~({64{1'b1}} << rsh);
    assign mag  = right_path ? shr : shl;

    always_comb begin
        result = 64'd0;
        nv     = 1'b0;
        nx     = 1'b0;
        if (is_nan) begin
            result = INT_MAX;
            nv     = 1'b1;
        end else if (too_big) begin
            // Exactly -2^63 is the single representable value at E=63.
            if (is_min) begin
                result = INT_MIN;
            end else begin
                result = sign ? INT_MIN : INT_MAX;
                nv     = 1'b1;
            end
        end else if (exp_zero) begin
            nx = |frac;
        end else if (below_one) begin
            nx = 1'b1;
        end else begin
            result = sign ? (~mag + 64'd1) : mag;
            nx     = right_path && (|lost);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            in        <= 64'd0;
            invalid   <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                in      <= result;
                invalid <= nv;
                inexact <= nx;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_int64.sv
// Randomized self-checking bench for fcvt_int64 against an arithmetic reference model.
// A scoreboard queue pairs each accepted operand with the result seen one cycle later.
module tb_fcvt_int64;

    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

    typedef struct packed {
        logic [63:0] val;
        logic        nv;
        logic        nx;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] fp;
    logic        out_valid;
    logic [63:0] in;
    logic        invalid;
    logic        inexact;

    exp_t exp_q[$];
    exp_t last_exp;
    logic mon_en;
    int   n_checks;
    int   n_fail;

    fcvt_int64 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .fp       (fp),
        .out_valid(out_valid),
        .in       (in),
        .invalid  (invalid),
        .inexact  (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference: value = (-1)^s * M * 2^(E-52), truncated toward zero by integer division.
    function automatic exp_t model(input logic [63:0] x);
        exp_t        r;
        int          e;
        int          ue;
        logic [63:0] m;
        logic [63:0] p;
        logic [63:0] mag;
        r = '0;
        e = int'(x[62:52]);
        if (e == 2047) begin
            r.nv  = 1'b1;
            r.val = (x[51:0] != 52'd0 || !x[63]) ? INT_MAX : INT_MIN;
            return r;
        end
        if (e == 0) begin
            r.nx = (x[51:0] != 52'd0);
            return r;
        end
        ue = e - 1023;
        if (ue < 0) begin
            r.nx = 1'b1;
            return r;
        end
        if (ue >= 63) begin
            if (x[63] && ue == 63 && x[51:0] == 52'd0) begin
                r.val = INT_MIN;
            end else begin
                r.nv  = 1'b1;
                r.val = x[63] ? INT_MIN : INT_MAX;
            end
            return r;
        end
        m = 64'h0010_0000_0000_0000 + {12'd0, x[51:0]};
        p = 64'd1;
        if (ue >= 52) begin
            for (int i = 0; i < ue - 52; i++) p = p * 64'd2;
            mag = m * p;
        end else begin
            for (int i = 0; i < 52 - ue; i++) p = p * 64'd2;
            mag  = m / p;
            r.nx = ((m % p) != 64'd0);
        end
        r.val = x[63] ? (64'd0 - mag) : mag;
        return r;
    endfunction

    function automatic logic [63:0] randFp();
        logic [63:0] raw;
        logic [10:0] e;
        int          sel;
        raw = {$urandom, $urandom};
        sel = int'($urandom_range(0, 11));
        case (sel)
            0:       e = 11'd0;
            1:       e = 11'd2047;
            2:       e = 11'd1086;
            3:       e = 11'($urandom_range(0, 2047));
            default: e = 11'($urandom_range(1010, 1090));
        endcase
        if ($urandom_range(0, 5) == 0) raw[51:0] = 52'd0;
        else if ($urandom_range(0, 3) == 0) raw[29:0] = 30'd0;
        return {raw[63], e, raw[51:0]};
    endfunction

    task automatic applyStimulus(input logic [63:0] value);
        @(negedge clk);
        fp       = value;
        in_valid = 1'b1;
        exp_q.push_back(model(value));
    endtask

    task automatic idleCycle();
        @(negedge clk);
        in_valid = 1'b0;
        fp       = {$urandom, $urandom};
    endtask

    // Each cycle either one scoreboard entry must emerge, or outputs must hold.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("out_valid", {63'd0, out_valid}, 64'd1);
                checkOutput("in", in, e.val);
                checkOutput("invalid", {63'd0, invalid}, {63'd0, e.nv});
                checkOutput("inexact", {63'd0, inexact}, {63'd0, e.nx});
                last_exp = e;
            end else begin
                checkOutput("idle_valid", {63'd0, out_valid}, 64'd0);
                checkOutput("hold_in", in, last_exp.val);
                checkOutput("hold_invalid", {63'd0, invalid}, {63'd0, last_exp.nv});
                checkOutput("hold_inexact", {63'd0, inexact}, {63'd0, last_exp.nx});
            end
        end
    end

    logic [63:0] directed[] = '{
        64'h0000_0000_0000_0000, 64'h4045_0000_0000_0000, 64'h426D_1A94_A200_0000,
        64'hC0C8_1C80_0000_0000, 64'h3FE8_0000_0000_0000, 64'hBFE0_0000_0000_0000,
        64'h0008_0000_0000_0000, 64'hC004_0000_0000_0000, 64'h43EF_FFFF_FFFF_FFFF,
        64'hC3EF_FFFF_FFFF_FFFF, 64'h43E0_0000_0000_0000, 64'hC3E0_0000_0000_0000,
        64'h7FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000,
        64'hFFF8_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h43DF_FFFF_FFFF_FFFF,
        64'h3FF0_0000_0000_0000, 64'h4330_0000_0000_0001, 64'h4340_0000_0000_0001
    };

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        last_exp = '0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        fp       = 64'h4045_0000_0000_0000;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_in", in, 64'd0);
        checkOutput("rst_invalid", {63'd0, invalid}, 64'd0);
        checkOutput("rst_inexact", {63'd0, inexact}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(64'h4045_0000_0000_0000));
        mon_en = 1'b1;

        foreach (directed[i]) applyStimulus(directed[i]);
        idleCycle();
        idleCycle();

        // Streaming burst of five distinct operands followed by two idle cycles.
        applyStimulus(64'h4059_0000_0000_0000);
        applyStimulus(64'hC059_0000_0000_0000);
        applyStimulus(64'h3FF8_0000_0000_0000);
        applyStimulus(64'h4415_0000_0000_0000);
        applyStimulus(64'h4000_0000_0000_0000);
        idleCycle();
        idleCycle();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) idleCycle();
            else applyStimulus(randFp());
        end
        idleCycle();
        idleCycle();

        // Reset in the middle of activity clears the registered result at once.
        applyStimulus(64'h4045_0000_0000_0000);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("midrst_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("midrst_in", in, 64'd0);
        checkOutput("midrst_invalid", {63'd0, invalid}, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_q.delete();
        last_exp = '0;
        mon_en   = 1'b1;
        idleCycle();
        idleCycle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
